// File: rtl/wt_stream_arbiter.sv
// Message-atomic round-robin merge of NUM_PORTS AXI-Stream block sources into one
// registered master stream; each beat's TUSER carries the index of its source port.
module wt_stream_arbiter #(
  parameter int NUM_PORTS            = 4,
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int SRC_ID_OFFSET        = 40
) (
  input  logic                                      axis_aclk,
  input  logic                                      axis_reset,
  input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic [NUM_PORTS-1:0]                      s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                      s_axis_tlast,
  output logic [NUM_PORTS-1:0]                      s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]           m_axis_tuser,
  output logic                                      m_axis_tvalid,
  output logic                                      m_axis_tlast,
  input  logic                                      m_axis_tready,
  output logic [2:0]                                grant_id,
  output logic                                      grant_busy,
  output logic                                      msg_done,
  output logic [15:0]                               msg_blocks
);
  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t        r_state;
  logic [2:0]    r_grant_id;
  logic [2:0]    r_last_grant;
  logic [15:0]   r_cnt;
  logic [15:0]   r_done_cnt;
  logic [DW-1:0] r_m_tdata;
  logic [UW-1:0] r_m_tuser;
  logic          r_m_tvalid;
  logic          r_m_tlast;

  logic          w_any;
  logic [2:0]    w_next;
  logic [DW-1:0] w_sel_data;
  logic [UW-1:0] w_sel_user;
  logic          w_sel_valid;
  logic          w_sel_last;
  logic          w_room;
  logic          w_accept;
  logic [15:0]   w_cnt_inc;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Round-robin search starting just after the previous owner, wrapping at NUM_PORTS.
  always_comb begin
    w_any  = 1'b0;
    w_next = r_last_grant;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      int idx;
      idx = int'(r_last_grant) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (!w_any && (k == idx) && s_axis_tvalid[k]) begin
          w_any  = 1'b1;
          w_next = 3'(k);
        end
      end
    end
  end

  // Owner's slave lane mux, source-ID insertion and handshake.
  always_comb begin
    w_sel_data    = '0;
    w_sel_user    = '0;
    w_sel_valid   = 1'b0;
    w_sel_last    = 1'b0;
    s_axis_tready = '0;
    w_room        = ~r_m_tvalid | m_axis_tready;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (3'(k) == r_grant_id) begin
        w_sel_data       = s_axis_tdata[k*DW +: DW];
        w_sel_user       = s_axis_tuser[k*UW +: UW];
        w_sel_valid      = s_axis_tvalid[k];
        w_sel_last       = s_axis_tlast[k];
        s_axis_tready[k] = (r_state == S_BUSY) & w_room;
      end
    end
    w_sel_user[SRC_ID_OFFSET +: 3] = r_grant_id;
    w_accept  = (r_state == S_BUSY) & w_sel_valid & w_room;
    w_cnt_inc = sat_inc(r_cnt);
  end

  // Grant FSM; ownership is released only when the owner's tlast beat is taken.
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      r_state      <= S_IDLE;
      r_grant_id   <= 3'd0;
      r_last_grant <= 3'(NUM_PORTS - 1);
      r_cnt        <= 16'd0;
      r_done_cnt   <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant_id <= w_next;
            r_cnt      <= 16'd0;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_accept) begin
            r_cnt <= w_cnt_inc;
            if (w_sel_last) begin
              r_last_grant <= r_grant_id;
              r_done_cnt   <= w_cnt_inc;
              r_state      <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Single-entry output register; holds while the master stalls.
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      r_m_tdata  <= '0;
      r_m_tuser  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
    end else if (w_accept) begin
      r_m_tdata  <= w_sel_data;
      r_m_tuser  <= w_sel_user;
      r_m_tvalid <= 1'b1;
      r_m_tlast  <= w_sel_last;
    end else if (m_axis_tready) begin
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
    end
  end

  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tuser  = r_m_tuser;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign grant_id      = r_grant_id;
  assign grant_busy    = (r_state == S_BUSY);
  assign msg_done      = r_m_tvalid & m_axis_tready & r_m_tlast;
  assign msg_blocks    = r_done_cnt;

endmodule
